// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol type, control tokens and helpers for encoder/decoder
package tmds_pkg;
  typedef logic [9:0] tmds_sym_t;
  localparam tmds_sym_t TMDS_CTRL_00 = 10'h354;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'h0AB;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'h154;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'h2AB;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b000, v[i]};
    return n;
  endfunction
  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    return c == 2'b00 ? TMDS_CTRL_00 : c == 2'b01 ? TMDS_CTRL_01 :
           c == 2'b10 ? TMDS_CTRL_10 : TMDS_CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_encoder.sv
// tmds_encoder: two-stage DVI 8b/10b TMDS channel encoder with running-disparity control
// Ports: clk pixel clock; rst_n sync active-low reset; de_i data enable;
//        data_i pixel byte (de_i=1); c_i control bits {c1,c0} (de_i=0); q_o 10-bit symbol, LSB first
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      de_i,
  input  logic [7:0] data_i,
  input  logic [1:0] c_i,
  output tmds_sym_t q_o
);
  logic [7:0] px;
  logic [3:0] n1d, n1_qm_d, n1_qm_q;
  logic use_xnor;
  logic [8:0] qm_d, qm_q;
  logic de_q;
  logic [1:0] c_q;
  tmds_sym_t q_d, q_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q, n1_s, bal;
  logic q8, keep, inv;
  // prefix parity of the input; the XNOR chain equals it with odd bits inverted
  for (genvar k = 0; k < 8; k++) begin : g_px
    assign px[k] = ^data_i[k:0];
  end
  assign n1d      = popcount8(data_i);
  assign use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !data_i[0]);
  assign qm_d     = {~use_xnor, px ^ (use_xnor ? 8'hAA : 8'h00)};
  assign n1_qm_d  = popcount8(qm_d[7:0]);
  // bal = n1 - n0 = 2*n1 - 8
  assign n1_s = CNT_W'(n1_qm_q);
  assign bal  = (n1_s <<< 1) - CNT_W'(8);
  assign q8   = qm_q[8];
  assign keep = cnt_q == '0 || bal == '0;
  assign inv  = (cnt_q > 0 && bal > 0) || (cnt_q < 0 && bal < 0);
  always_comb begin
    q_d   = !de_q ? ctrl_token(c_q) :
            keep  ? {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]} :
            inv   ? {1'b1, q8, ~qm_q[7:0]} : {1'b0, q8, qm_q[7:0]};
    cnt_d = !de_q ? '0 :
            keep  ? (q8 ? cnt_q + bal : cnt_q - bal) :
            inv   ? cnt_q + (q8 ? CNT_W'(2) : '0) - bal :
                    cnt_q - (q8 ? '0 : CNT_W'(2)) + bal;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qm_q    <= '0;
      n1_qm_q <= '0;
      de_q    <= 1'b0;
      c_q     <= 2'b00;
      q_q     <= TMDS_CTRL_00;
      cnt_q   <= '0;
    end else begin
      qm_q    <= qm_d;
      n1_qm_q <= n1_qm_d;
      de_q    <= de_i;
      c_q     <= c_i;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end
  assign q_o = q_q;
endmodule
